// File: rtl/bist_sig_controller.sv
// rtl/bist_sig_controller.sv - BIST sequencer: clears the MISR, runs the pattern loop, checks the signature
module bist_sig_controller #(
    parameter int PATTERN_COUNT = 8,
    parameter int SIG_WIDTH     = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SIG_WIDTH-1:0] signature_in,
    input  logic [SIG_WIDTH-1:0] golden_sig,
    output logic                 ora_clear_n,
    output logic                 tpg_load,
    output logic                 tpg_enable,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [SIG_WIDTH-1:0] sig_captured
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(PATTERN_COUNT - 1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   counter_q, counter_d;
    logic                   ora_clear_n_q, ora_clear_n_d;
    logic                   tpg_load_q, tpg_load_d;
    logic                   tpg_enable_q, tpg_enable_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [SIG_WIDTH-1:0]   sig_captured_q, sig_captured_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            counter_q      <= '0;
            ora_clear_n_q  <= 1'b0;
            tpg_load_q     <= 1'b0;
            tpg_enable_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            sig_captured_q <= '0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            ora_clear_n_q  <= ora_clear_n_d;
            tpg_load_q     <= tpg_load_d;
            tpg_enable_q   <= tpg_enable_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            sig_captured_q <= sig_captured_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        pass_d         = pass_q;
        sig_captured_d = sig_captured_q;

        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR: begin
                counter_d = '0;
                state_d   = RUN;
            end
            RUN: begin
                counter_d = counter_q + CNT_WIDTH'(1);
                if (counter_q == LAST_CNT) state_d = CAPTURE;
            end
            CAPTURE: begin
                // Pre-edge MISR value is taken; the MISR's own update at this edge is discarded.
                sig_captured_d = signature_in;
                pass_d         = (signature_in == golden_sig);
                state_d        = DONE;
            end
            DONE:    if (start) state_d = CLEAR;
            default: state_d = IDLE;
        endcase

        if (state_d == CLEAR) begin
            pass_d         = 1'b0;
            sig_captured_d = '0;
        end

        if (abort) begin
            state_d        = IDLE;
            counter_d      = counter_q;
            pass_d         = 1'b0;
            sig_captured_d = sig_captured_q;
        end

        // Outputs are decoded from the next state so they land in flops alongside it.
        ora_clear_n_d = (state_d == RUN) || (state_d == CAPTURE);
        tpg_load_d    = (state_d == CLEAR);
        tpg_enable_d  = (state_d == RUN);
        busy_d        = (state_d == CLEAR) || (state_d == RUN) || (state_d == CAPTURE);
        done_d        = (state_d == DONE);
    end

    assign ora_clear_n  = ora_clear_n_q;
    assign tpg_load     = tpg_load_q;
    assign tpg_enable   = tpg_enable_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign sig_captured = sig_captured_q;

endmodule

// File: tb/tb_bist_sig_controller.sv
// tb/tb_bist_sig_controller.sv - directed-vector bench for bist_sig_controller
module tb_bist_sig_controller;

    localparam int PC = 8;

    logic       clock;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] signature_in;
    logic [3:0] golden_sig;
    logic       ora_clear_n;
    logic       tpg_load;
    logic       tpg_enable;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] sig_captured;

    int n_vec;
    int n_miscompare;

    bist_sig_controller #(.PATTERN_COUNT(PC), .SIG_WIDTH(4), .CNT_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .signature_in (signature_in),
        .golden_sig   (golden_sig),
        .ora_clear_n  (ora_clear_n),
        .tpg_load     (tpg_load),
        .tpg_enable   (tpg_enable),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .sig_captured (sig_captured)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic clr_n, input logic ld, input logic en,
                              input logic bsy, input logic dn);
        expect_eq({tag, ".ora_clear_n"}, 32'(ora_clear_n), 32'(clr_n));
        expect_eq({tag, ".tpg_load"},    32'(tpg_load),    32'(ld));
        expect_eq({tag, ".tpg_enable"},  32'(tpg_enable),  32'(en));
        expect_eq({tag, ".busy"},        32'(busy),        32'(bsy));
        expect_eq({tag, ".done"},        32'(done),        32'(dn));
    endtask

    // Full test from a start pulse through DONE; optional stray start pulse on RUN cycle 3.
    task automatic run_test(input string tag, input logic [3:0] sig, input logic exp_pass,
                            input bit mid_start);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outs({tag, ".clear"}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_eq({tag, ".clear.pass"}, 32'(pass), 32'd0);
        expect_eq({tag, ".clear.sig"},  32'(sig_captured), 32'd0);
        for (int i = 1; i <= PC; i++) begin
            signature_in = ~sig;
            if (mid_start && i == 3) start = 1'b1;
            tick();
            start = 1'b0;
            check_outs($sformatf("%s.run%0d", tag, i), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        tick();
        check_outs({tag, ".capture"}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        signature_in = sig;
        tick();
        signature_in = 4'b1010;
        check_outs({tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_eq({tag, ".pass"}, 32'(pass), 32'(exp_pass));
        expect_eq({tag, ".sig"},  32'(sig_captured), 32'(sig));
        tick();
        expect_eq({tag, ".hold.done"}, 32'(done), 32'd1);
        expect_eq({tag, ".hold.sig"},  32'(sig_captured), 32'(sig));
    endtask

    initial begin
        n_vec        = 0;
        n_miscompare = 0;
        reset        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        signature_in = 4'b0000;
        golden_sig   = 4'b0110;

        repeat (3) tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_eq("reset.pass", 32'(pass), 32'd0);
        expect_eq("reset.sig",  32'(sig_captured), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_outs($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            expect_eq($sformatf("idle%0d.pass", i), 32'(pass), 32'd0);
        end

        run_test("pass", 4'b0110, 1'b1, 1'b0);
        run_test("fail", 4'b0111, 1'b0, 1'b0);
        run_test("restart", 4'b0110, 1'b1, 1'b0);
        run_test("busy_start", 4'b0110, 1'b1, 1'b1);

        // Abort from DONE: pass drops, captured signature is kept.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outs("abort_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_eq("abort_done.pass", 32'(pass), 32'd0);
        expect_eq("abort_done.sig",  32'(sig_captured), 32'b0110);

        // Abort together with start on the 4th RUN cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_outs("abort_pre", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_outs("abort_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset on the 5th RUN cycle, between edges.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check_outs("areset_pre", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_outs("areset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        check_outs("areset_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule

// File: doc/bist_sig_controller.md
Name: bist_sig_controller

Overview:
- Sequencing and signature-check stage for the full-adder BIST loop.
- Consumes the 4-bit MISR signature and drives the MISR's active-low clear, plus the test-pattern generator's load/enable.
- On a start request it clears the ORA, runs exactly PATTERN_COUNT compression cycles, captures the signature and compares it against a golden value.
- Reports done/pass to the system test master.

Parameters:
- PATTERN_COUNT, 8: number of compression cycles per test (full adder has 2^3 input patterns); legal range 1..255.
- SIG_WIDTH, 4: width of the MISR signature and golden value.
- CNT_WIDTH, 8: width of the internal pattern counter; must satisfy 2^CNT_WIDTH > PATTERN_COUNT.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  test request, sampled on the clock edge; level or pulse, acted on only in IDLE or DONE.
- abort  input  1  synchronous abort; highest priority after reset.
- signature_in  input  SIG_WIDTH  MISR parallel output.
- golden_sig  input  SIG_WIDTH  expected signature; must be stable from start through DONE.
- ora_clear_n  output  1  active-low clear to MISR reset pin; driven directly from a flop, never decoded combinationally.
- tpg_load  output  1  one-cycle seed load to the pattern generator.
- tpg_enable  output  1  pattern generator advance enable.
- busy  output  1  high in CLEAR, RUN, CAPTURE.
- done  output  1  high in DONE.
- pass  output  1  compare result, valid while done=1.
- sig_captured  output  SIG_WIDTH  captured signature, held through DONE.

Behaviour:
- All outputs are registered Moore outputs, updated together with the state register.
- Reset values (reset low, asynchronous):
  - state=IDLE, counter=0
  - ora_clear_n=0, tpg_load=0, tpg_enable=0
  - busy=0, done=0, pass=0
  - sig_captured=0
- States: IDLE, CLEAR, RUN, CAPTURE, DONE.
- IDLE:
  - ora_clear_n=0, tpg_enable=0.
  - start=1 -> CLEAR.
- CLEAR (exactly 1 cycle):
  - ora_clear_n=0, tpg_load=1, busy=1.
  - done, pass and sig_captured clear to 0.
  - counter <= 0.
  - -> RUN.
- RUN (exactly PATTERN_COUNT cycles):
  - ora_clear_n=1, tpg_enable=1, busy=1.
  - counter increments each edge.
  - On the edge where counter==PATTERN_COUNT-1 -> CAPTURE.
  - The MISR therefore compresses on exactly PATTERN_COUNT edges before capture.
- CAPTURE (exactly 1 cycle):
  - ora_clear_n=1 (the clear must not fire before sampling), tpg_enable=0, busy=1.
  - At the closing edge: sig_captured <= signature_in, pass <= (signature_in==golden_sig).
  - -> DONE.
  - The MISR also clocks at this edge; this is harmless because the pre-edge value is captured.
- DONE:
  - done=1, busy=0, ora_clear_n=0; pass and sig_captured held.
  - start=1 -> CLEAR (restart).
  - Otherwise remain in DONE indefinitely.
- Latency: start sampled at edge E0 -> done=1 after edge E0+PATTERN_COUNT+2 (10 edges for the default).
- abort=1 in any state:
  - Next state IDLE, ora_clear_n=0, tpg_enable=0, busy=0, done=0, pass=0.
  - sig_captured keeps its last value.
  - abort wins over start in the same cycle.
- start while busy (CLEAR/RUN/CAPTURE) is ignored; there is no restart mid-test.
- Asynchronous reset mid-test: immediate return to reset values; ora_clear_n low clears the MISR in the same instant.
- The counter never wraps within a test; it reloads in CLEAR.

Test Plan:
- Reset then idle: hold reset low 3 cycles, release, start=0 for 5 cycles -> ora_clear_n=0, busy=0, done=0, pass=0 throughout.
- Nominal pass (PATTERN_COUNT=8, golden_sig=4'b0110):
  - One-cycle start pulse -> CLEAR for 1 cycle with tpg_load=1, then ora_clear_n=1/tpg_enable=1 for exactly 8 cycles.
  - Bench drives signature_in=4'b0110 in the CAPTURE cycle -> done=1 on the 10th edge after start, pass=1, sig_captured=4'b0110.
- Nominal fail: same run with signature_in=4'b0111 at capture -> done=1, pass=0, sig_captured=4'b0111.
- Abort mid-RUN: assert abort on the 4th RUN cycle, together with start=1 -> next cycle IDLE, ora_clear_n=0, tpg_enable=0, done=0; start ignored.
- Restart from DONE and start-while-busy:
  - After a passing run, pulse start -> done/pass drop in CLEAR, a full 8-cycle run repeats.
  - A start pulse during RUN does not change the counter or timing.
- Async reset mid-RUN: pull reset low on the 5th RUN cycle between edges -> ora_clear_n=0 and busy=0 immediately, without waiting for a clock edge.
